// File: rtl/textlcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 8-bit write-only sequencer.
package textlcd_ctrl_pkg;

    localparam int CNT_W    = 24;
    localparam int INIT_LEN = 6;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_EHIGH = 3'd3,
        ST_HOLD  = 3'd4,
        ST_EXEC  = 3'd5,
        ST_IDLE  = 3'd6
    } state_e;

    // Entry 0 is the rightmost element: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/textlcd_ctrl.sv
// HD44780 sequencer: power-up wait, fixed init sequence, then timed single-byte
// writes accepted over a valid/ready handshake.
module textlcd_ctrl
    import textlcd_ctrl_pkg::*;
#(
    parameter int unsigned T_PWRUP = 32'd750000,
    parameter int unsigned T_SETUP = 32'd2,
    parameter int unsigned T_EPW   = 32'd12,
    parameter int unsigned T_HOLD  = 32'd2,
    parameter int unsigned T_EXEC  = 32'd2000,
    parameter int unsigned T_LONG  = 32'd80000
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               init_done_q, init_done_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               long_q, long_d;
    logic               e_q, e_d;
    logic               ready_q, ready_d;
    logic               cnt_zero_s;

    // Counter reload value: phase length minus one, so each phase lasts exactly its parameter.
    function automatic logic [CNT_W-1:0] load_val(input state_e st, input logic long_cmd);
        case (st)
            ST_PWRUP: load_val = CNT_W'(T_PWRUP - 32'd1);
            ST_SETUP: load_val = CNT_W'(T_SETUP - 32'd1);
            ST_EHIGH: load_val = CNT_W'(T_EPW - 32'd1);
            ST_HOLD:  load_val = CNT_W'(T_HOLD - 32'd1);
            ST_EXEC:  load_val = long_cmd ? CNT_W'(T_LONG - 32'd1) : CNT_W'(T_EXEC - 32'd1);
            default:  load_val = {CNT_W{1'b0}};
        endcase
    endfunction

    assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});

    // Next-state, counter and latched-byte logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        long_d      = long_q;
        if (!cnt_zero_s) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_PWRUP: begin
                if (cnt_zero_s) state_d = ST_LOAD;
                else            state_d = ST_PWRUP;
            end
            ST_LOAD: begin
                state_d = ST_SETUP;
                rs_d    = 1'b0;
                data_d  = INIT_ROM[idx_q];
                long_d  = is_long_cmd(1'b0, INIT_ROM[idx_q]);
            end
            ST_SETUP: begin
                if (cnt_zero_s) state_d = ST_EHIGH;
                else            state_d = ST_SETUP;
            end
            ST_EHIGH: begin
                if (cnt_zero_s) state_d = ST_HOLD;
                else            state_d = ST_EHIGH;
            end
            ST_HOLD: begin
                if (cnt_zero_s) state_d = ST_EXEC;
                else            state_d = ST_HOLD;
            end
            ST_EXEC: begin
                if (!cnt_zero_s) begin
                    state_d = ST_EXEC;
                end else if (!init_done_q && (idx_q < IDX_W'(INIT_LEN - 1))) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_LOAD;
                end else begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    rs_d    = cmd_rs;
                    data_d  = cmd_data;
                    long_d  = is_long_cmd(cmd_rs, cmd_data);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PWRUP;
        endcase

        if (state_d != state_q) begin
            cnt_d = load_val(state_d, long_d);
        end else begin
            cnt_d = cnt_d;
        end

        e_d     = (state_d == ST_EHIGH);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops every pin immediately, E included.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= CNT_W'(T_PWRUP - 32'd1);
            idx_q       <= {IDX_W{1'b0}};
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            long_q      <= 1'b0;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            long_q      <= long_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign init_done = init_done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_textlcd_ctrl.sv
// Directed bench for textlcd_ctrl with short timing parameters.
module tb_textlcd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;

    int         rise_q[$];
    logic [7:0] rdata_q[$];
    logic       rrs_q[$];
    int         width_q[$];
    logic       e_prev  = 1'b0;
    int         rise_at = 0;

    textlcd_ctrl #(
        .T_PWRUP(32'd20), .T_SETUP(32'd1), .T_EPW(32'd3),
        .T_HOLD(32'd1), .T_EXEC(32'd4), .T_LONG(32'd10)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .init_done(init_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // E-pulse monitor: cycle of each rising edge, the byte on the bus, pulse width.
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            rise_q.push_back(cyc - base);
            rdata_q.push_back(lcd_data);
            rrs_q.push_back(lcd_rs);
            rise_at = cyc;
        end
        if (!lcd_e && e_prev) width_q.push_back(cyc - rise_at);
        e_prev = lcd_e;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rise_q.delete();
        rdata_q.delete();
        rrs_q.delete();
        width_q.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy},      32'd1);
        check_eq({tag, "_done"},  {31'd0, init_done}, 32'd0);
        check_eq({tag, "_rs"},    {31'd0, lcd_rs},    32'd0);
        check_eq({tag, "_rw"},    {31'd0, lcd_rw},    32'd0);
        check_eq({tag, "_e"},     {31'd0, lcd_e},     32'd0);
        check_eq({tag, "_data"},  {24'd0, lcd_data},  32'd0);
    endtask

    task automatic wait_ready(input string tag, output int at);
        int t = 0;
        while (!cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
        at = cyc;
    endtask

    // Expects release at cycle 0 (base); optionally a byte held on cmd_valid throughout.
    task automatic init_sequence(input string tag, input bit pend, input logic [7:0] pdata);
        int exp_rise[6] = '{22, 32, 42, 52, 62, 78};
        logic [7:0] exp_data[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        int at;
        int back;
        wait_ready({tag, "_init"}, at);
        check_eq({tag, "_ready_cycle"}, at - base, 32'd86);
        check_eq({tag, "_done_with_ready"}, {31'd0, init_done}, 32'd1);
        check_eq({tag, "_pulse_count"}, rise_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < rise_q.size(); i++) begin
            check_eq($sformatf("%s_rise%0d", tag, i), rise_q[i], exp_rise[i]);
            check_eq($sformatf("%s_data%0d", tag, i), {24'd0, rdata_q[i]}, {24'd0, exp_data[i]});
            check_eq($sformatf("%s_rs%0d", tag, i), {31'd0, rrs_q[i]}, 32'd0);
        end
        for (int i = 0; i < 6 && i < width_q.size(); i++)
            check_eq($sformatf("%s_width%0d", tag, i), width_q[i], 32'd3);
        if (pend) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            check_eq({tag, "_pend_data"}, {24'd0, lcd_data}, {24'd0, pdata});
            check_eq({tag, "_pend_rs"}, {31'd0, lcd_rs}, 32'd1);
            @(negedge clk);
            wait_ready({tag, "_pend"}, back);
            check_eq({tag, "_pend_back"}, back - base, 32'd96);
            check_eq({tag, "_pend_count"}, rise_q.size(), 32'd7);
            if (rise_q.size() >= 7) begin
                check_eq({tag, "_pend_rise"}, rise_q[6], 32'd88);
                check_eq({tag, "_pend_rdata"}, {24'd0, rdata_q[6]}, {24'd0, pdata});
            end
        end
    endtask

    task automatic send_cmd(input string tag, input logic rs, input logic [7:0] data, input int exp_dly);
        int hs;
        int back;
        clear_mon();
        cmd_rs = rs;
        cmd_data = data;
        cmd_valid = 1'b1;
        wait_ready({tag, "_hs"}, hs);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq({tag, "_c1_data"}, {24'd0, lcd_data}, {24'd0, data});
        check_eq({tag, "_c1_rs"}, {31'd0, lcd_rs}, {31'd0, rs});
        check_eq({tag, "_c1_ready"}, {31'd0, cmd_ready}, 32'd0);
        check_eq({tag, "_c1_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        wait_ready({tag, "_back"}, back);
        check_eq({tag, "_delay"}, back - hs, exp_dly);
        check_eq({tag, "_pulses"}, rise_q.size(), 32'd1);
        if (rise_q.size() > 0) check_eq({tag, "_e_start"}, rise_q[0] - (hs - base), 32'd2);
        if (width_q.size() > 0) check_eq({tag, "_e_width"}, width_q[0], 32'd3);
    endtask

    initial begin
        int hs[3];
        int back;
        int t;
        logic [7:0] burst[3] = '{8'h48, 8'h49, 8'h21};
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_rs = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outs("por");

        // Byte held from reset release: must wait for the end of init.
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
        clear_mon();
        init_sequence("init", 1'b1, 8'h55);

        @(negedge clk);
        send_cmd("d41", 1'b1, 8'h41, 10);
        send_cmd("clr", 1'b0, 8'h01, 16);
        send_cmd("c00", 1'b0, 8'h00, 10);
        send_cmd("c80", 1'b0, 8'h80, 10);
        send_cmd("home", 1'b0, 8'h02, 16);
        send_cmd("d01", 1'b1, 8'h01, 10);

        // Three bytes back to back with cmd_valid never dropped.
        clear_mon();
        cmd_rs = 1'b1;
        cmd_data = burst[0];
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready("burst", hs[k]);
            @(posedge clk);
            #1;
            if (k < 2) cmd_data = burst[k+1];
            else       cmd_valid = 1'b0;
            @(negedge clk);
        end
        wait_ready("burst_end", back);
        check_eq("burst_gap01", hs[1] - hs[0], 32'd10);
        check_eq("burst_gap12", hs[2] - hs[1], 32'd10);
        check_eq("burst_pulses", rise_q.size(), 32'd3);
        for (int k = 0; k < 3 && k < rdata_q.size(); k++)
            check_eq($sformatf("burst_data%0d", k), {24'd0, rdata_q[k]}, {24'd0, burst[k]});

        // Reset asserted while E is high.
        cmd_rs = 1'b1;
        cmd_data = 8'h41;
        cmd_valid = 1'b1;
        wait_ready("rst_hs", back);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t = 0;
        while (!lcd_e && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst_saw_e", {31'd0, lcd_e}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outs("midpulse");
        repeat (2) @(negedge clk);
        check_reset_outs("held");
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
        #1;
        clear_mon();
        init_sequence("reinit", 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
